// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: FSM state type and default operand width for serial_adder
package serial_adder_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;
  localparam int DEFAULT_WIDTH = 8;
endpackage

// File: rtl/fa.sv
// fa: 1-bit full adder cell (a, b, cin -> sum, carry)
module fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b ^ cin;
  assign carry = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_adder.sv
// serial_adder: LSB-first bit-serial adder on fa (clk, rst, start, a_in, b_in, cin_in -> busy, done, sum_out, cout; ovf when SERIAL_ADDER_OVF_EN)
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int CW = $clog2(WIDTH);
  state_t           state_q;
  logic [WIDTH-1:0] a_sr_q, b_sr_q, acc_d;
  logic [WIDTH-2:0] acc_q;
  logic [CW-1:0]    cnt_q;
  logic             c_q, s, co;
  fa u_fa (.a(a_sr_q[0]), .b(b_sr_q[0]), .cin(c_q), .sum(s), .carry(co));
  always_comb acc_d = {s, acc_q};
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum_out <= '0;
      cout    <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          a_sr_q  <= a_in;
          b_sr_q  <= b_in;
          c_q     <= cin_in;
          cnt_q   <= '0;
          busy    <= 1'b1;
          state_q <= SHIFT;
        end
        SHIFT: begin
          a_sr_q <= a_sr_q >> 1;
          b_sr_q <= b_sr_q >> 1;
          acc_q  <= acc_d[WIDTH-1:1];
          c_q    <= co;
          cnt_q  <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            sum_out <= acc_d;
            cout    <= co;
`ifdef SERIAL_ADDER_OVF_EN
            ovf     <= c_q ^ co;
`endif
            busy    <= 1'b0;
            done    <= 1'b1;
            state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: randomized self-checking bench for serial_adder at WIDTH=8 and WIDTH=2
module tb_serial_adder;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] start = '0;
  logic [1:0] cin = '0;
  logic [1:0] busy, done, cout;
  logic [7:0] a8 = '0, b8 = '0, sum8;
  logic [1:0] a2 = '0, b2 = '0, sum2;
`ifdef SERIAL_ADDER_OVF_EN
  logic [1:0] ovf;
`endif
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start[0]), .a_in(a8), .b_in(b8), .cin_in(cin[0]),
    .busy(busy[0]), .done(done[0]), .sum_out(sum8), .cout(cout[0])
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf[0])
`endif
  );
  serial_adder #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start[1]), .a_in(a2), .b_in(b2), .cin_in(cin[1]),
    .busy(busy[1]), .done(done[1]), .sum_out(sum2), .cout(cout[1])
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf[1])
`endif
  );
  int     wid[2] = '{8, 2};
  int     ph[2] = '{-1, -1};
  longint exp_res[2] = '{0, 0};
  longint pend_res[2] = '{0, 0};
  bit     exp_ovf[2] = '{0, 0};
  bit     pend_ovf[2] = '{0, 0};
  bit     armed = 1'b0;
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, got, exp, $time);
    end
  endtask
  function automatic longint sx(input longint v, input int w);
    return v >= (longint'(1) << (w - 1)) ? v - (longint'(1) << w) : v;
  endfunction
  function automatic logic [8:0] got_res(input int d);
    return d == 0 ? {cout[0], sum8} : {7'b0, cout[1], sum2};
  endfunction
  always @(posedge clk) begin
    longint av, bv, sv, lim;
    for (int d = 0; d < 2; d++) begin
      av  = d == 0 ? longint'(a8) : longint'(a2);
      bv  = d == 0 ? longint'(b8) : longint'(b2);
      lim = longint'(1) << (wid[d] - 1);
      if (rst) begin
        ph[d] = -1;
        exp_res[d] = 0;
        exp_ovf[d] = 1'b0;
        armed = 1'b1;
      end else if (ph[d] < 0) begin
        if (start[d]) begin
          ph[d] = 0;
          pend_res[d] = av + bv + longint'(cin[d]);
          sv = sx(av, wid[d]) + sx(bv, wid[d]) + longint'(cin[d]);
          pend_ovf[d] = sv > lim - 1 || sv < -lim;
        end
      end else begin
        ph[d]++;
        if (ph[d] == wid[d]) begin
          exp_res[d] = pend_res[d];
          exp_ovf[d] = pend_ovf[d];
        end else if (ph[d] == wid[d] + 1) ph[d] = -1;
      end
    end
  end
  always @(negedge clk) begin
    if (armed) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("busy_w%0d", wid[d]), busy[d], ph[d] >= 0 && ph[d] < wid[d]);
        chk($sformatf("done_w%0d", wid[d]), done[d], ph[d] == wid[d]);
        chk($sformatf("result_w%0d", wid[d]), got_res(d), exp_res[d]);
`ifdef SERIAL_ADDER_OVF_EN
        chk($sformatf("ovf_w%0d", wid[d]), ovf[d], exp_ovf[d]);
`endif
      end
    end
  end
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c, input logic [8:0] exp);
    int k = 1;
    int nb = 0;
    a8 = a;
    b8 = b;
    cin[0] = c;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    a8 = 8'($urandom);
    b8 = 8'($urandom);
    while (k < 40 && !done[0]) begin
      nb += int'(busy[0]);
      @(negedge clk);
      k++;
    end
    chk("op8_done_seen", done[0], 1);
    chk("op8_done_cycle", k, 9);
    chk("op8_busy_cycles", nb, 8);
    chk("op8_result", {cout[0], sum8}, exp);
    @(negedge clk);
    chk("op8_done_pulse", done[0], 0);
  endtask
  task automatic drive(input int d, input logic [7:0] a, input logic [7:0] b, input logic c, input logic s);
    if (d == 0) begin
      a8 = a;
      b8 = b;
    end else begin
      a2 = a[1:0];
      b2 = b[1:0];
    end
    cin[d] = c;
    start[d] = s;
  endtask
  task automatic rnd(input int d, input int n);
    logic [7:0] ea, eb;
    logic       ec;
    int         k;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      ea = 8'($urandom);
      eb = 8'($urandom);
      ec = 1'($urandom);
      if (wid[d] == 2) begin
        ea[7:2] = '0;
        eb[7:2] = '0;
      end
      drive(d, ea, eb, ec, 1'b1);
      k = 0;
      do begin
        @(negedge clk);
        k++;
        if (!done[d]) drive(d, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
      end while (!done[d] && k < 40);
      start[d] = 1'b0;
      chk($sformatf("rnd_w%0d_done", wid[d]), done[d], 1);
      chk($sformatf("rnd_w%0d_sum", wid[d]), got_res(d), 9'(ea) + 9'(eb) + 9'(ec));
      @(negedge clk);
    end
  endtask
  initial begin
    int nd;
    logic prev;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy[0], 0);
    chk("rst_done", done[0], 0);
    chk("rst_sum", sum8, 0);
    chk("rst_cout", cout[0], 0);
    rst = 1'b0;
    op8(8'h03, 8'h05, 1'b0, 9'h008);
    op8(8'hFF, 8'h01, 1'b0, 9'h100);
    op8(8'hAA, 8'h55, 1'b1, 9'h100);
    a8 = 8'h10;
    b8 = 8'h20;
    cin[0] = 1'b0;
    start[0] = 1'b1;
    nd = 0;
    prev = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done[0]) begin
        nd++;
        chk("b2b_result", {cout[0], sum8}, 9'h030);
      end
      chk("b2b_single_pulse", prev & done[0], 0);
      prev = done[0];
    end
    start[0] = 1'b0;
    chk("b2b_done_count", nd, 2);
    a8 = 8'h0F;
    b8 = 8'h01;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_in_shift", busy[0], 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", busy[0], 0);
    chk("abort_done", done[0], 0);
    chk("abort_sum", sum8, 0);
    chk("abort_cout", cout[0], 0);
    repeat (12) begin
      @(negedge clk);
      chk("abort_no_done", done[0], 0);
    end
    op8(8'h0F, 8'h01, 1'b0, 9'h010);
`ifdef SERIAL_ADDER_OVF_EN
    op8(8'h7F, 8'h01, 1'b0, 9'h080);
    chk("ovf_7f_01", ovf[0], 1);
    op8(8'h80, 8'h80, 1'b0, 9'h100);
    chk("ovf_80_80", ovf[0], 1);
    op8(8'h01, 8'h01, 1'b0, 9'h002);
    chk("ovf_01_01", ovf[0], 0);
`endif
    fork
      rnd(0, 1000);
      rnd(1, 1000);
    join
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
